branch_bht_ctrl: RTL

Branch redirect controller with a parametrised bimodal branch history table (BHT). It sits between fetch (F), decode (D) and execute (X) in the 3-stage RISC-V pipeline. It predicts conditional branches at F with saturating counters, resolves them at D, and trains the table on resolution. It generates PC-select and kill requests with the priority X JALR > D mispredict > F prediction. It also counts resolved branches and mispredicts for performance monitoring.

---
 rtl/branch_bht_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/branch_bht_ctrl.sv
// Branch redirect controller with a bimodal BHT: predicts B-types at F, resolves at D,
// arbitrates next-PC select / kills (X JALR > D mispredict > F prediction), counts branches.
module branch_bht_ctrl #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned CNT_BITS    = 2,
  parameter int unsigned CNT_INIT    = 1,
  parameter int unsigned PERF_BITS   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [XLEN-1:0]      instF,
  input  logic [XLEN-1:0]      instD,
  input  logic [XLEN-1:0]      instX,
  input  logic                 validF,
  input  logic                 validD,
  input  logic                 validX,
  input  logic [XLEN-1:0]      pcF,
  input  logic [XLEN-1:0]      pcD,
  input  logic                 brTakenD,
  input  logic                 stallF,
  output logic [2:0]           PCSel_F_out,
  output logic                 killD_req_next,
  output logic                 killX_req_next,
  output logic                 predTakenF,
  output logic [PERF_BITS-1:0] brCount,
  output logic [PERF_BITS-1:0] mispCount
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  localparam logic [4:0] OP_B    = 5'b11000;
  localparam logic [4:0] OP_JAL  = 5'b11011;
  localparam logic [4:0] OP_JALR = 5'b11001;

  localparam logic [2:0] SEL_PC4     = 3'd0;
  localparam logic [2:0] SEL_F_IMM   = 3'd1;
  localparam logic [2:0] SEL_X_ALU   = 3'd2;
  localparam logic [2:0] SEL_D_IMM   = 3'd3;
  localparam logic [2:0] SEL_D_PC4   = 3'd4;

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_RST = CNT_BITS'(CNT_INIT);

  logic [CNT_BITS-1:0]  bht_q [BHT_ENTRIES];
  logic                 pred_d_q, pred_d_d;
  logic [PERF_BITS-1:0] br_cnt_q, misp_cnt_q;

  logic [IDX_W-1:0]    idx_f, idx_d;
  logic                f_is_b, f_is_jal, d_is_b, x_is_jalr;
  logic                x_kill, d_misp, train, pred_f;
  logic [CNT_BITS-1:0] cnt_cur, cnt_nxt;
  logic [2:0]          pc_sel;
  logic                kill_d, kill_x;

  assign idx_f     = pcF[IDX_W+1:2];
  assign idx_d     = pcD[IDX_W+1:2];
  assign f_is_b    = (instF[6:2] == OP_B);
  assign f_is_jal  = (instF[6:2] == OP_JAL);
  assign d_is_b    = (instD[6:2] == OP_B);
  assign x_is_jalr = (instX[6:2] == OP_JALR);

  assign pred_f = validF && f_is_b && bht_q[idx_f][CNT_BITS-1];
  assign x_kill = validX && x_is_jalr;
  assign d_misp = validD && d_is_b && (brTakenD != pred_d_q);
  // Wrong-path (X JALR flush) and stalled branches must not train.
  assign train  = validD && d_is_b && !stallF && !x_kill;

  // Saturating counter step for the D-stage branch.
  assign cnt_cur = bht_q[idx_d];
  always_comb begin
    cnt_nxt = cnt_cur;
    if (brTakenD) begin
      if (cnt_cur != CNT_MAX) cnt_nxt = cnt_cur + CNT_BITS'(1);
    end else begin
      if (cnt_cur != '0) cnt_nxt = cnt_cur - CNT_BITS'(1);
    end
  end

  // Redirect arbitration: X JALR > D mispredict > F prediction.
  always_comb begin
    pc_sel = SEL_PC4;
    kill_d = 1'b0;
    kill_x = 1'b0;
    if (x_kill) begin
      pc_sel = SEL_X_ALU;
      kill_d = 1'b1;
      kill_x = 1'b1;
    end else if (d_misp) begin
      pc_sel = brTakenD ? SEL_D_IMM : SEL_D_PC4;
      kill_d = 1'b1;
    end else if (validF) begin
      if (f_is_jal)                pc_sel = SEL_F_IMM;
      else if (f_is_b && pred_f)   pc_sel = SEL_F_IMM;
    end
  end

  // A flushed D slot holds no live prediction, so the kill wins over the stall hold.
  always_comb begin
    pred_d_d = pred_d_q;
    if (kill_d)       pred_d_d = 1'b0;
    else if (!stallF) pred_d_d = pred_f;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CNT_RST;
      pred_d_q   <= 1'b0;
      br_cnt_q   <= '0;
      misp_cnt_q <= '0;
    end else begin
      pred_d_q <= pred_d_d;
      if (train) begin
        bht_q[idx_d] <= cnt_nxt;
        br_cnt_q     <= br_cnt_q + PERF_BITS'(1);
        if (d_misp) misp_cnt_q <= misp_cnt_q + PERF_BITS'(1);
      end
    end
  end

  assign PCSel_F_out    = pc_sel;
  assign killD_req_next = kill_d;
  assign killX_req_next = kill_x;
  assign predTakenF     = pred_f;
  assign brCount        = br_cnt_q;
  assign mispCount      = misp_cnt_q;

  // Only the opcode field and index bits are consumed.
  logic unused_bits;
  assign unused_bits = ^{instF[XLEN-1:7], instF[1:0], instD[XLEN-1:7], instD[1:0],
                         instX[XLEN-1:7], instX[1:0], pcF[XLEN-1:IDX_W+2], pcF[1:0],
                         pcD[XLEN-1:IDX_W+2], pcD[1:0]};

endmodule
